pipeline_control_unit: RTL
==========================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall_EX  in  1  load-use hazard request from the forwarding unit.
REQ-005 br_taken  in  1  EX-stage control transfer resolved taken (branch/jal/jalr).
REQ-006 imem_resp  in  1  instruction memory read completes this cycle.
REQ-007 dmem_req  in  1  MEM-stage instruction is a load/store needing memory.
REQ-008 dmem_resp  in  1  data memory access completes this cycle.
REQ-009 cnt_clr  in  1  synchronous clear of all performance counters.
REQ-010 imem_read  out  1  instruction fetch request.
REQ-011 load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  out  1 each  stage register enables.
REQ-012 flush_IF_ID, flush_ID_EX  out  1 each  load a NOP control word/IR into that register.
REQ-013 bubble_EX_MEM  out  1  load a NOP into EX/MEM instead of EX results.
REQ-014 pcmux_redirect  out  1  PC takes EX target, not PC+4.
REQ-015 ir_buf_load  out  1  capture imem rdata into the fetch holding buffer.
REQ-016 ir_buf_sel  out  1  IF/ID takes the holding buffer, not imem rdata.
REQ-017 cnt_load_use, cnt_mem_stall, cnt_flush  out  16 each  performance counters.

Function
REQ-018 Stage controls SHALL be combinational from inputs and state (zero latency); counters and FSM registered.
REQ-019 FSM SHALL have states RUN and MEM_WAIT, plus flags i_done, d_done.
REQ-020 In RUN: imem_miss = ~imem_resp; dmem_miss = dmem_req & ~dmem_resp; mem_stall = imem_miss | dmem_miss.
REQ-021 mem_stall in RUN: all five load_* = 0, no flush/bubble/redirect; next state MEM_WAIT; i_done <= imem_resp; d_done <= ~dmem_req | dmem_resp.
REQ-022 In RUN, imem_resp & dmem_miss: ir_buf_load = 1.
REQ-023 In MEM_WAIT: imem_read = ~i_done; imem_resp sets i_done and asserts ir_buf_load; dmem_resp sets d_done.
REQ-024 MEM_WAIT exits when (i_done|imem_resp) & (d_done|dmem_resp); loads are 0 until the exit cycle, then resolve as in RUN (REQ-026..028) and the state returns to RUN.
REQ-025 ir_buf_sel = 1 in the exit cycle iff the instruction was captured in the buffer in an earlier cycle.
REQ-026 Priority: mem_stall > stall_EX > br_taken > normal advance.
REQ-027 stall_EX without mem_stall: load_pc = load_IF_ID = load_ID_EX = 0; load_EX_MEM = load_MEM_WB = 1; bubble_EX_MEM = 1; br_taken ignored this cycle.
REQ-028 br_taken without stall_EX or mem_stall: all loads = 1; pcmux_redirect = 1; flush_IF_ID = flush_ID_EX = 1.
REQ-029 Normal advance: all loads = 1; flushes, bubble, redirect = 0; imem_read = 1 in RUN.
REQ-030 cnt_load_use SHALL increment on each REQ-027 cycle; cnt_mem_stall on each cycle with all loads 0 due to memory; cnt_flush on each REQ-028 cycle.
REQ-031 Counters SHALL saturate at 0xFFFF; cnt_clr has priority over increment.

Reset
REQ-032 While rst_n = 0: state RUN; i_done = d_done = 0; counters 0; all load_*, flush_*, bubble, redirect, ir_buf_* and imem_read = 0.
REQ-033 Reset asserted mid-MEM_WAIT SHALL abandon the wait; first post-reset cycle behaves as RUN with fresh fetch.

Structure
REQ-034 The FSM state enum and a PERF_CNT_W = 16 constant SHALL live in the shared rv32i_types package.
REQ-035 One sub-module, perf_counter (width-parameterised, saturating, sync clear), SHALL be instantiated three times.

Verification
REQ-036 imem_resp = 1 every cycle, dmem_req = 0, no hazards -> all loads 1 every cycle, counters remain 0.
REQ-037 stall_EX = 1 for 1 cycle -> PC/IF_ID/ID_EX hold, bubble_EX_MEM = 1, cnt_load_use = 1.
REQ-038 stall_EX = 1 and br_taken = 1 in the same cycle -> stall wins, no redirect, cnt_flush = 0; br_taken next cycle -> redirect with both flushes, cnt_flush = 1.
REQ-039 dmem_req = 1 with dmem_resp after 3 cycles and imem_resp in the first cycle -> ir_buf_load pulses once; loads 0 for 3 cycles; exit cycle has ir_buf_sel = 1; cnt_mem_stall = 3.
REQ-040 cnt_mem_stall preset to 0xFFFE with 3 stall cycles -> reads 0xFFFF; cnt_clr pulse -> 0.
REQ-041 rst_n low during MEM_WAIT -> all outputs 0 immediately; after release, state RUN and imem_read = 1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline control slice: FSM state and counter width.
package rv32i_types;

    localparam int unsigned PERF_CNT_W = 16;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pcu_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_load_t;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous clear that takes priority over increment.
module perf_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Five-stage pipeline sequencing: memory stalls, load-use bubbles, branch flushes,
// fetch holding-buffer control and performance counters.
module pipeline_control_unit
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_EX,
    input  logic                  br_taken,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic                  cnt_clr,
    output logic                  imem_read,
    output logic                  load_pc,
    output logic                  load_IF_ID,
    output logic                  load_ID_EX,
    output logic                  load_EX_MEM,
    output logic                  load_MEM_WB,
    output logic                  flush_IF_ID,
    output logic                  flush_ID_EX,
    output logic                  bubble_EX_MEM,
    output logic                  pcmux_redirect,
    output logic                  ir_buf_load,
    output logic                  ir_buf_sel,
    output logic [PERF_CNT_W-1:0] cnt_load_use,
    output logic [PERF_CNT_W-1:0] cnt_mem_stall,
    output logic [PERF_CNT_W-1:0] cnt_flush
);

    pcu_state_e  state_q, state_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;

    stage_load_t ld;
    logic        fetch_rd;
    logic        flush_if;
    logic        flush_id;
    logic        bubble;
    logic        redirect;
    logic        buf_load;
    logic        buf_sel;
    logic        instr_ok;
    logic        data_ok;
    logic        advance;
    logic        inc_lu;
    logic        inc_ms;
    logic        inc_fl;

    // Next-state and stage-control decode
    always_comb begin
        state_d  = state_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        ld       = '0;
        fetch_rd = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        bubble   = 1'b0;
        redirect = 1'b0;
        buf_load = 1'b0;
        buf_sel  = 1'b0;
        instr_ok = 1'b0;
        data_ok  = 1'b0;
        inc_lu   = 1'b0;
        inc_ms   = 1'b0;
        inc_fl   = 1'b0;

        if (state_q == ST_MEM_WAIT) begin
            fetch_rd = ~i_done_q;
            instr_ok = i_done_q | imem_resp;
            data_ok  = d_done_q | dmem_resp;
            buf_load = imem_resp & ~i_done_q;
        end else begin
            fetch_rd = 1'b1;
            instr_ok = imem_resp;
            data_ok  = ~dmem_req | dmem_resp;
            buf_load = imem_resp & ~data_ok;
        end

        advance = instr_ok & data_ok;

        if (!advance) begin
            // Freeze everything; remember which side already completed
            state_d  = ST_MEM_WAIT;
            i_done_d = instr_ok;
            d_done_d = data_ok;
            inc_ms   = 1'b1;
        end else begin
            state_d  = ST_RUN;
            i_done_d = 1'b0;
            d_done_d = 1'b0;
            buf_sel  = (state_q == ST_MEM_WAIT) & i_done_q;
            if (stall_EX) begin
                ld.ex_mem = 1'b1;
                ld.mem_wb = 1'b1;
                bubble    = 1'b1;
                inc_lu    = 1'b1;
            end else if (br_taken) begin
                ld       = '1;
                redirect = 1'b1;
                flush_if = 1'b1;
                flush_id = 1'b1;
                inc_fl   = 1'b1;
            end else begin
                ld = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    // Controls are forced low for the whole reset window, not just at the next edge
    assign imem_read      = rst_n & fetch_rd;
    assign load_pc        = rst_n & ld.pc;
    assign load_IF_ID     = rst_n & ld.if_id;
    assign load_ID_EX     = rst_n & ld.id_ex;
    assign load_EX_MEM    = rst_n & ld.ex_mem;
    assign load_MEM_WB    = rst_n & ld.mem_wb;
    assign flush_IF_ID    = rst_n & flush_if;
    assign flush_ID_EX    = rst_n & flush_id;
    assign bubble_EX_MEM  = rst_n & bubble;
    assign pcmux_redirect = rst_n & redirect;
    assign ir_buf_load    = rst_n & buf_load;
    assign ir_buf_sel     = rst_n & buf_sel;

    perf_counter #(.W(PERF_CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_lu),
        .cnt   (cnt_load_use)
    );

    perf_counter #(.W(PERF_CNT_W)) u_cnt_mem_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_ms),
        .cnt   (cnt_mem_stall)
    );

    perf_counter #(.W(PERF_CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (inc_fl),
        .cnt   (cnt_flush)
    );

endmodule
